add_accum_stage: RTL and testbench

ADD_ACCUM_STAGE -- requirements
Module: add_accum_stage

---
 rtl/add_accum_stage_pkg.sv | 19 +
 rtl/add_accum_stage_adder32_4.sv | 40 ++++
 rtl/add_accum_stage.sv | 91 +++++++++
 tb/tb_add_accum_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/add_accum_stage_pkg.sv
// Shared types and constants for the frame accumulator stage.
// Holds the FSM state encoding, default carry-field width and beat-count helpers.
package add_accum_stage_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int HI_W_DEFAULT = 8;
   localparam int COUNT_W      = 16;

   // Beat counter sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/add_accum_stage_adder32_4.sv
// 32-bit adder built from 4-bit carry-lookahead blocks chained block to block.
// sum[32] is the carry-out of the full 32-bit addition.
module adder32_4 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [32:0] sum
);

   // One 4-bit lookahead block: returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic c1, c2, c3, c4;
      g  = x & y;
      p  = x ^ y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c4, p ^ {c3, c2, c1, c0}};
   endfunction

   function automatic logic [32:0] add32(input logic [31:0] x, input logic [31:0] y);
      logic        cy;
      logic [31:0] s;
      logic [4:0]  blk;
      cy = 1'b0;
      s  = '0;
      for (int k = 0; k < 8; k++) begin
         blk          = cla4(x[4*k +: 4], y[4*k +: 4], cy);
         s[4*k +: 4]  = blk[3:0];
         cy           = blk[4];
      end
      return {cy, s};
   endfunction

   assign sum = add32(a, b);

endmodule

// File: rtl/add_accum_stage.sv
// Frame accumulator: sums unsigned 32-bit beats into a {carry field, low word}
// total per frame and holds the result under ready/valid backpressure.
module add_accum_stage
   import add_accum_stage_pkg::*;
#(
   parameter int HI_W = HI_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32+HI_W-1:0]  out_sum,
   output logic                out_ovf,
   output logic [COUNT_W-1:0]  out_count
);

   state_t              state;
   state_t              state_nxt;

   logic [31:0]         acc_lo_p1;
   logic [HI_W-1:0]     hi_p1;
   logic [COUNT_W-1:0]  count_p1;
   logic                ovf_p1;

   logic                accept;
   logic                take;
   logic                start;
   logic [31:0]         add_a;
   logic [32:0]         add_sum;
   logic [HI_W-1:0]     hi_nxt;
   logic                wrap;

   assign out_valid = (state == HOLD);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;

   // Any beat outside ACCUM opens a fresh frame, so the running sum is ignored.
   assign start = (state != ACCUM);
   assign add_a = start ? 32'd0 : acc_lo_p1;

   adder32_4 u_adder (
      .a   (add_a),
      .b   (in_data),
      .sum (add_sum)
   );

   assign hi_nxt = start ? '0 : hi_p1 + HI_W'(add_sum[32]);
   assign wrap   = !start && add_sum[32] && (&hi_p1);

   always_comb begin
      state_nxt = state;
      if (accept) begin
         state_nxt = in_last ? HOLD : ACCUM;
      end else if (take) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- accumulate stage: registers double as the held result ----
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_lo_p1 <= '0;
         hi_p1     <= '0;
         count_p1  <= '0;
         ovf_p1    <= 1'b0;
      end else if (accept) begin
         acc_lo_p1 <= add_sum[31:0];
         hi_p1     <= hi_nxt;
         count_p1  <= start ? {{(COUNT_W-1){1'b0}}, 1'b1} : sat_inc(count_p1);
         ovf_p1    <= start ? 1'b0 : (ovf_p1 | wrap);
      end
   end

   assign out_sum   = {hi_p1, acc_lo_p1};
   assign out_ovf   = ovf_p1;
   assign out_count = count_p1;

endmodule

// File: tb/tb_add_accum_stage.sv
// Directed bench for add_accum_stage: single beat, carry, carry-field wrap,
// backpressure, back-to-back frames and reset mid-frame / during hold.
module tb_add_accum_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] out_sum;
   logic        out_ovf;
   logic [15:0] out_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   add_accum_stage #(.HI_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .out_count (out_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic result(input string tag, input logic [39:0] s, input logic [15:0] c, input logic o);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_sum"}, out_sum, s);
      check({tag, "_count"}, out_count, c);
      check({tag, "_ovf"}, out_ovf, o);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("drain_valid", out_valid, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_sum", out_sum, 40'h0);
      check("rst_count", out_count, 16'h0);
      check("rst_ovf", out_ovf, 1'b0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", in_ready, 1'b1);

      // Single-beat frame
      beat(32'h0000_0005, 1'b1);
      result("single", 40'h00_0000_0005, 16'd1, 1'b0);
      drain();

      // Carry out of the low word into the carry field
      beat(32'hFFFF_FFFF, 1'b0);
      check("carry_mid_valid", out_valid, 1'b0);
      beat(32'h0000_0002, 1'b1);
      result("carry", 40'h01_0000_0001, 16'd2, 1'b0);
      drain();

      // Idle cycles inside a frame leave it untouched
      beat(32'h0000_0003, 1'b0);
      tick();
      tick();
      tick();
      check("accum_idle_valid", out_valid, 1'b0);
      beat(32'h0000_0004, 1'b1);
      result("gap", 40'h00_0000_0007, 16'd2, 1'b0);
      drain();

      // 257 all-ones beats wrap the 8-bit carry field
      for (int i = 0; i < 256; i++) beat(32'hFFFF_FFFF, 1'b0);
      check("wrap_mid_valid", out_valid, 1'b0);
      beat(32'hFFFF_FFFF, 1'b1);
      result("wrap", 40'h00_FFFF_FEFF, 16'd257, 1'b1);

      // Backpressure: result held, no beats accepted
      in_valid = 1'b1;
      in_data  = 32'h0000_00AA;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_ready", in_ready, 1'b0);
         check("bp_sum", out_sum, 40'h00_FFFF_FEFF);
         check("bp_count", out_count, 16'd257);
         check("bp_ovf", out_ovf, 1'b1);
         check("bp_valid", out_valid, 1'b1);
      end
      in_valid = 1'b0;

      // Take and start a new single-beat frame in the same cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0010;
      in_last   = 1'b1;
      #1;
      check("bb_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      result("bb", 40'h00_0000_0010, 16'd1, 1'b0);

      // Take while starting a multi-beat frame
      beat(32'h0000_0020, 1'b0);
      check("bb2_mid_valid", out_valid, 1'b0);
      beat(32'h0000_0001, 1'b1);
      result("bb2", 40'h00_0000_0021, 16'd2, 1'b0);
      out_ready = 1'b0;
      drain();

      // Reset mid-frame discards the partial sum
      beat(32'h0000_0001, 1'b0);
      beat(32'h0000_0002, 1'b0);
      beat(32'h0000_0003, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_sum", out_sum, 40'h0);
      beat(32'h0000_0007, 1'b1);
      result("midrst", 40'h00_0000_0007, 16'd1, 1'b0);

      // Reset during hold drops the pending result
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("holdrst_valid", out_valid, 1'b0);
      check("holdrst_count", out_count, 16'h0);
      check("holdrst_ready", in_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
